basic_timer: RTL and testbench

BASIC_TIMER -- requirements
Module: basic_timer

---
 rtl/timer_pkg.sv | 10 +
 rtl/tim_prescaler.sv | 24 ++
 rtl/basic_timer.sv | 102 ++++++++++
 tb/tb_basic_timer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and widths for the basic timer block.
package timer_pkg;
  localparam int TIM_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;
endpackage

// File: rtl/tim_prescaler.sv
// Prescaler: divides clk by (psc+1), producing a one-cycle tick while enabled.
module tim_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [TIM_W-1:0] psc,
  output logic             tick
);

  logic [TIM_W-1:0] cnt;

  // Tick is combinational so the counter can react on the same edge it rolls over.
  assign tick = en && (cnt == psc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else if (en)           cnt <= cnt + TIM_W'(1);
  end

endmodule

// File: rtl/basic_timer.sv
// Up-counting timer with preloaded PSC/ARR/CCR shadows, sticky update flag and PWM.
module basic_timer
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [TIM_W-1:0] tim_psc,
  input  logic [TIM_W-1:0] tim_arr,
  input  logic [TIM_W-1:0] tim_ccr,
  input  logic             tim_en,
  input  logic             flag_clr,
  output logic [TIM_W-1:0] tim_cnt,
  output logic             update_evt,
  output logic             uif,
  output logic             pwm_out,
  output logic             running
);

  state_t           state, state_d;
  logic [TIM_W-1:0] psc_sh, arr_sh, ccr_sh;
  logic [TIM_W-1:0] psc_d, arr_d, ccr_d, cnt_d;
  logic             pre_clr, pre_en, tick, wrap, pwm_d;

  assign pre_clr = (state == LOAD) && tim_en;
  assign pre_en  = (state == RUN) && tim_en;
  assign running = (state == RUN);

  tim_prescaler u_psc (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .psc   (psc_sh),
    .tick  (tick)
  );

  always_comb begin
    state_d = state;
    cnt_d   = tim_cnt;
    psc_d   = psc_sh;
    arr_d   = arr_sh;
    ccr_d   = ccr_sh;
    wrap    = 1'b0;
    case (state)
      IDLE: if (tim_en) state_d = LOAD;
      LOAD: begin
        if (tim_en) begin
          state_d = RUN;
          psc_d   = tim_psc;
          arr_d   = tim_arr;
          ccr_d   = tim_ccr;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!tim_en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (tim_cnt == arr_sh) begin
            // Wrap: shadows pick up whatever the datapath wrote during the period.
            wrap  = 1'b1;
            cnt_d = '0;
            psc_d = tim_psc;
            arr_d = tim_arr;
            ccr_d = tim_ccr;
          end else begin
            cnt_d = tim_cnt + TIM_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Computed from next-state values so the registered PWM lines up with tim_cnt.
    pwm_d = (state_d == RUN) && (cnt_d < ccr_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tim_cnt    <= '0;
      psc_sh     <= '0;
      arr_sh     <= '0;
      ccr_sh     <= '0;
      update_evt <= 1'b0;
      uif        <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      state      <= state_d;
      tim_cnt    <= cnt_d;
      psc_sh     <= psc_d;
      arr_sh     <= arr_d;
      ccr_sh     <= ccr_d;
      update_evt <= wrap;
      pwm_out    <= pwm_d;
      if (wrap)          uif <= 1'b1;
      else if (flag_clr) uif <= 1'b0;
    end
  end

endmodule

// File: tb/tb_basic_timer.sv
// Directed bench for basic_timer; observations packed as {cnt, update_evt, uif, pwm_out, running}.
module tb_basic_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tim_psc, tim_arr, tim_ccr;
  logic        tim_en, flag_clr;
  logic [15:0] tim_cnt;
  logic        update_evt, uif, pwm_out, running;

  int vectors    = 0;
  int miscompares = 0;

  basic_timer dut (
    .clk        (clk),
    .reset      (reset),
    .tim_psc    (tim_psc),
    .tim_arr    (tim_arr),
    .tim_ccr    (tim_ccr),
    .tim_en     (tim_en),
    .flag_clr   (flag_clr),
    .tim_cnt    (tim_cnt),
    .update_evt (update_evt),
    .uif        (uif),
    .pwm_out    (pwm_out),
    .running    (running)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] obs();
    return {tim_cnt, update_evt, uif, pwm_out, running};
  endfunction

  function automatic logic [19:0] pk(input int c, input logic u, input logic f,
                                      input logic p, input logic r);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, u, f, p, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    e = pk(0, 0, 0, 0, 0);
    #2;
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_async: got %h want %h (cnt,upd,uif,pwm,run)", obs(), e);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  // PSC=0 ARR=3 CCR=2, then CCR=5 written mid-period takes effect at the next wrap.
  task automatic test_basic();
    logic [19:0] e;
    int c, ccr;
    pulse_reset();
    tim_psc = 16'd0; tim_arr = 16'd3; tim_ccr = 16'd2; tim_en = 1'b1;
    step();
    e = pk(0, 0, 0, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL basic_load: got %h want %h", obs(), e);
    end
    for (int i = 0; i <= 16; i++) begin
      step();
      c   = i % 4;
      ccr = (i >= 12) ? 5 : 2;
      e   = pk(c, (i > 0) && (c == 0), i >= 4, c < ccr, 1'b1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL basic_run[%0d]: got %h want %h", i, obs(), e);
      end
      if (i == 10) tim_ccr = 16'd5;
    end
  endtask

  task automatic test_prescaler();
    logic [19:0] e;
    pulse_reset();
    tim_psc = 16'd2; tim_arr = 16'd1; tim_ccr = 16'd0; tim_en = 1'b1;
    step();
    for (int i = 0; i <= 12; i++) begin
      step();
      e = pk((i / 3) % 2, (i > 0) && (i % 6 == 0), i >= 6, 1'b0, 1'b1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL prescaler[%0d]: got %h want %h", i, obs(), e);
      end
    end
  endtask

  // ARR 3 -> 1 mid-period; flag_clr tests continue on the resulting 2-cycle period.
  task automatic test_preload_and_flag_clr();
    logic [19:0] e;
    int   exp_cnt[9] = '{0, 1, 2, 3, 0, 1, 0, 1, 0};
    logic fc[6]      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int   fcnt[6]    = '{1, 0, 1, 0, 1, 0};
    logic fuif[6]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    pulse_reset();
    tim_psc = 16'd0; tim_arr = 16'd3; tim_ccr = 16'd0; tim_en = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      step();
      e = pk(exp_cnt[i], (i >= 4) && (exp_cnt[i] == 0), i >= 4, 1'b0, 1'b1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL preload[%0d]: got %h want %h", i, obs(), e);
      end
      if (i == 1) tim_arr = 16'd1;
    end
    for (int i = 0; i < 6; i++) begin
      flag_clr = fc[i];
      step();
      e = pk(fcnt[i], fcnt[i] == 0, fuif[i], 1'b0, 1'b1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL flag_clr[%0d]: got %h want %h", i, obs(), e);
      end
    end
    flag_clr = 1'b0;
  endtask

  task automatic test_disable();
    logic [19:0] e[8];
    e = '{pk(0,0,0,1,1), pk(1,0,0,1,1), pk(2,0,0,0,1), pk(2,0,0,0,0),
          pk(2,0,0,0,0), pk(2,0,0,0,0), pk(0,0,0,1,1), pk(1,0,0,1,1)};
    pulse_reset();
    tim_psc = 16'd0; tim_arr = 16'd3; tim_ccr = 16'd2; tim_en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) tim_en = 1'b0;
      if (i == 5) tim_en = 1'b1;
      step();
      vectors++;
      if (obs() !== e[i]) begin
        miscompares++;
        $display("FAIL disable[%0d]: got %h want %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [19:0] e;
    pulse_reset();
    tim_psc = 16'd0; tim_arr = 16'd3; tim_ccr = 16'd3; tim_en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    e = pk(2, 0, 1, 1, 1);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL midrun_pre: got %h want %h", obs(), e);
    end
    #2;
    reset = 1'b1;
    #1;
    e = pk(0, 0, 0, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL midrun_async: got %h want %h", obs(), e);
    end
    step();
    step();
    tim_en = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) tim_en = 1'b1;
      step();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL midrun_hold[%0d]: got %h want %h", i, obs(), e);
      end
    end
    step();
    e = pk(0, 0, 0, 1, 1);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL midrun_restart: got %h want %h", obs(), e);
    end
  endtask

  initial begin
    reset = 1'b1; tim_psc = '0; tim_arr = '0; tim_ccr = '0;
    tim_en = 1'b0; flag_clr = 1'b0;
    test_reset();
    test_basic();
    test_prescaler();
    test_preload_and_flag_clr();
    test_disable();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
